mtimer_irq_unit: RTL and testbench

- Memory-mapped machine timer (mtime/mtimecmp) attached to the memory-stage bus beside data_memory.
- Produces the `interrupt` request consumed by the datapath/CSR trap logic.
- Holds the request under a level/ack handshake until the core signals trap entry.
- Address decode is local; the core's memory-stage signals (alu_out_mw as address, wdata_mw, rd_en, wr_en) drive it directly.

---
 rtl/mtimer_irq_unit.sv | 140 ++++++++++++++
 tb/tb_mtimer_irq_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_irq_unit.sv
// mtimer_irq_unit
//   Memory-mapped machine timer (mtime / mtimecmp) sitting on the memory-stage
//   bus next to data memory. A prescaled 64-bit counter is compared against
//   mtimecmp. The registered compare status drives a level interrupt request
//   that is held until the core acknowledges trap entry.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   addr       byte address from the memory stage
//   wdata      store data
//   rd_en      load strobe
//   wr_en      store strobe (already gated by interrupt/exception)
//   intr_ack   one-cycle pulse when the core enters the trap
//   rdata      combinational read data (0 unless a load hits the window)
//   hit        access falls in the 32-byte register window and is word aligned
//   timer_pend registered status: EN && mtime >= mtimecmp
//   interrupt  level interrupt request to the datapath
//
// Register map (word offsets from BASE_ADDR)
//   0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 CTRL {PRESC at [8 +: PRESC_W], EN at [0]}, 0x14-0x1C read 0.
module mtimer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int unsigned PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        intr_ack,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        timer_pend,
    output logic        interrupt
);

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_CTRL     = 3'd4;

    localparam logic [PRESC_W-1:0] CNT_ONE = 1;

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q, cmp_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               timer_pend_q, timer_pend_d;
    logic               interrupt_q, interrupt_d;

    logic [2:0] word;
    logic       we;
    logic       tick;

    assign word = addr[4:2];
    assign hit  = (rd_en | wr_en) && (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
    assign we   = wr_en && hit;

    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        presc_d = presc_q;
        tick    = en_q && (cnt_q == presc_q);

        if (!en_q || tick) cnt_d = '0;
        else               cnt_d = cnt_q + CNT_ONE;

        if (tick) mtime_d = mtime_q + 64'd1;

        // A store to either mtime half replaces the whole increment for
        // that cycle: the written half takes wdata, the other half holds.
        if (we) begin
            case (word)
                W_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
                W_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
                W_CMP_LO:   cmp_d   = {cmp_q[63:32], wdata};
                W_CMP_HI:   cmp_d   = {wdata, cmp_q[31:0]};
                W_CTRL: begin
                    en_d    = wdata[0];
                    presc_d = wdata[8 +: PRESC_W];
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end

        timer_pend_d = en_q && (mtime_q >= cmp_q);

        // Edge detect on the next pend value so the request rises together
        // with timer_pend and falls together with it; a new edge beats ack.
        if (timer_pend_d && !timer_pend_q) interrupt_d = 1'b1;
        else if (intr_ack)                 interrupt_d = 1'b0;
        else if (!timer_pend_d)            interrupt_d = 1'b0;
        else                               interrupt_d = interrupt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q      <= '0;
            cmp_q        <= '1;
            en_q         <= 1'b0;
            presc_q      <= '0;
            cnt_q        <= '0;
            timer_pend_q <= 1'b0;
            interrupt_q  <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            cmp_q        <= cmp_d;
            en_q         <= en_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            timer_pend_q <= timer_pend_d;
            interrupt_q  <= interrupt_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en && hit) begin
            case (word)
                W_MTIME_LO: rdata = mtime_q[31:0];
                W_MTIME_HI: rdata = mtime_q[63:32];
                W_CMP_LO:   rdata = cmp_q[31:0];
                W_CMP_HI:   rdata = cmp_q[63:32];
                W_CTRL:     rdata = {{(24 - PRESC_W){1'b0}}, presc_q, 7'b0, en_q};
                default:    rdata = '0;
            endcase
        end
    end

    assign timer_pend = timer_pend_q;
    assign interrupt  = interrupt_q;

endmodule

// File: tb/tb_mtimer_irq_unit.sv
// Bench for mtimer_irq_unit: directed scenarios with literal expectations plus
// a randomized phase, all outputs compared every cycle against a behavioural
// model of the timer.
module tb_mtimer_irq_unit;

    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] O_LO   = 32'h00;
    localparam logic [31:0] O_HI   = 32'h04;
    localparam logic [31:0] O_CLO  = 32'h08;
    localparam logic [31:0] O_CHI  = 32'h0C;
    localparam logic [31:0] O_CTRL = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        rd_en, wr_en, intr_ack;
    logic [31:0] rdata;
    logic        hit, timer_pend, interrupt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mtimer_irq_unit #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_en(rd_en),
        .wr_en(wr_en), .intr_ack(intr_ack), .rdata(rdata), .hit(hit),
        .timer_pend(timer_pend), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] mtime;
        logic [63:0] cmp;
        logic        en;
        logic [7:0]  presc;
        logic [7:0]  cnt;
        logic        pend;
        logic        irq;
    } mstate_t;

    mstate_t m;

    function automatic bit exp_hit(logic [31:0] a, logic rd, logic wr);
        return (rd || wr) && (a >= BASE) && (a < BASE + 32'd32) && ((a % 4) == 0);
    endfunction

    function automatic logic [31:0] exp_rdata(mstate_t s, logic [31:0] a, logic rd, logic wr);
        int off;
        if (!(rd && exp_hit(a, rd, wr))) return 32'd0;
        off = int'((a - BASE) / 4);
        case (off)
            0: return s.mtime[31:0];
            1: return s.mtime[63:32];
            2: return s.cmp[31:0];
            3: return s.cmp[63:32];
            4: return {16'd0, s.presc, 7'd0, s.en};
            default: return 32'd0;
        endcase
    endfunction

    function automatic mstate_t model_step(mstate_t s, logic [31:0] a, logic [31:0] wd,
                                           logic rd, logic wr, logic ack);
        mstate_t n;
        bit tick;
        int off;
        n     = s;
        tick  = s.en && (s.cnt == s.presc);
        n.cnt = (s.en && !tick) ? s.cnt + 8'd1 : 8'd0;
        n.mtime = tick ? s.mtime + 64'd1 : s.mtime;
        n.pend = s.en && (s.mtime >= s.cmp);
        n.irq  = (n.pend && !s.pend) || (n.pend && s.irq && !ack);
        if (wr && exp_hit(a, rd, wr)) begin
            off = int'((a - BASE) / 4);
            case (off)
                0: n.mtime = {s.mtime[63:32], wd};
                1: n.mtime = {wd, s.mtime[31:0]};
                2: n.cmp[31:0]  = wd;
                3: n.cmp[63:32] = wd;
                4: begin n.en = wd[0]; n.presc = wd[15:8]; n.cnt = 8'd0; end
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{mtime: 64'd0, cmp: 64'hFFFF_FFFF_FFFF_FFFF, en: 1'b0,
                         presc: 8'd0, cnt: 8'd0, pend: 1'b0, irq: 1'b0};
        else      m <= model_step(m, addr, wdata, rd_en, wr_en, intr_ack);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("hit", hit, exp_hit(addr, rd_en, wr_en));
            check("rdata", rdata, exp_rdata(m, addr, rd_en, wr_en));
            check("timer_pend", timer_pend, m.pend);
            check("interrupt", interrupt, m.irq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic k);
        @(posedge clk);
        #2;
        rd_en = r; wr_en = w; addr = a; wdata = d; intr_ack = k;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Returns 2 time units after the edge that captured the write.
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        drive(1'b0, 1'b1, BASE + off, d, 1'b0);
        idle();
    endtask

    // Zero-wait read between edges; leaves the bus idle again.
    task automatic expect_rd(input string name, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd_en = 1'b1; addr = BASE + off;
        #1 v = rdata;
        rd_en = 1'b0; addr = 32'd0;
        check(name, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        bit          found;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wdata = 32'd0; intr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;

        // reset values
        expect_rd("rst_mtime_lo", O_LO, 32'd0);
        expect_rd("rst_mtime_hi", O_HI, 32'd0);
        expect_rd("rst_cmp_lo", O_CLO, 32'hFFFF_FFFF);
        expect_rd("rst_cmp_hi", O_CHI, 32'hFFFF_FFFF);
        expect_rd("rst_ctrl", O_CTRL, 32'd0);

        // async reset mid-count with pend/irq active
        wr(O_CHI, 32'd0);
        wr(O_CLO, 32'd2);
        wr(O_CTRL, 32'd1);
        repeat (7) idle();
        check("pre_rst_pend", timer_pend, 1'b1);
        check("pre_rst_irq", interrupt, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_pend", timer_pend, 1'b0);
        check("async_rst_irq", interrupt, 1'b0);
        check("async_rst_hit", hit, 1'b0);
        check("async_rst_rdata", rdata, 32'd0);
        expect_rd("async_rst_mtime", O_LO, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // prescaler: EN, PRESC=3 -> one tick per 4 cycles
        wr(O_CTRL, 32'h0000_0301);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (i == 35) expect_rd("presc_c35", O_LO, 32'd8);
            if (i == 36) expect_rd("presc_c36", O_LO, 32'd9);
            if (i == 39) expect_rd("presc_c39", O_LO, 32'd9);
            if (i == 40) expect_rd("presc_c40", O_LO, 32'd10);
        end

        // full 64-bit wrap
        wr(O_CTRL, 32'd0);
        wr(O_LO, 32'hFFFF_FFFF);
        wr(O_HI, 32'hFFFF_FFFF);
        wr(O_CTRL, 32'd1);
        idle();
        expect_rd("wrap_lo", O_LO, 32'd0);
        expect_rd("wrap_hi", O_HI, 32'd0);

        // carry LO -> HI
        wr(O_CTRL, 32'd0);
        wr(O_LO, 32'hFFFF_FFFF);
        wr(O_HI, 32'd0);
        wr(O_CTRL, 32'd1);
        idle();
        expect_rd("carry_lo", O_LO, 32'd0);
        expect_rd("carry_hi", O_HI, 32'd1);

        // compare, interrupt, ack, re-arm
        wr(O_CTRL, 32'd0);
        wr(O_LO, 32'd0);
        wr(O_HI, 32'd0);
        wr(O_CHI, 32'd0);
        wr(O_CLO, 32'd20);
        wr(O_CTRL, 32'd1);
        for (int i = 1; i <= 25; i++) begin
            idle();
            if (i == 20) check("cmp_pend_c20", timer_pend, 1'b0);
            if (i == 21) begin
                check("cmp_pend_c21", timer_pend, 1'b1);
                check("cmp_irq_c21", interrupt, 1'b1);
                expect_rd("cmp_mtime_c21", O_LO, 32'd21);
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle();
        check("ack_irq", interrupt, 1'b0);
        check("ack_pend", timer_pend, 1'b1);
        wr(O_CLO, 32'd100);
        idle();
        check("rearm_pend", timer_pend, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            idle();
            if (interrupt) begin
                found = 1'b1;
                expect_rd("rearm_mtime", O_LO, 32'd101);
                check("rearm_pend_hi", timer_pend, 1'b1);
            end
        end
        check("rearm_irq_seen", found, 1'b1);

        // store collides with a tick
        wr(O_LO, 32'd5);
        expect_rd("collide_lo", O_LO, 32'd5);
        idle();
        expect_rd("collide_next", O_LO, 32'd6);

        // reserved offset, misaligned and out-of-window accesses
        wr(O_CTRL, 32'd0);
        wr(O_LO, 32'h1234);
        wr(O_HI, 32'h55);
        drive(1'b0, 1'b1, BASE + 32'h14, 32'hDEAD_BEEF, 1'b0);
        #1 check("resv_wr_hit", hit, 1'b1);
        idle();
        rd_en = 1'b1; addr = BASE + 32'h14;
        #1 check("resv_rd_hit", hit, 1'b1);
        check("resv_rd_data", rdata, 32'd0);
        rd_en = 1'b0; addr = 32'd0;
        drive(1'b0, 1'b1, BASE + 32'h2, 32'hFFFF_0301, 1'b0);
        #1 check("misal_hit", hit, 1'b0);
        drive(1'b1, 1'b1, BASE + 32'h20, 32'h0000_0001, 1'b0);
        #1 check("outside_hit", hit, 1'b0);
        idle();
        expect_rd("keep_lo", O_LO, 32'h1234);
        expect_rd("keep_hi", O_HI, 32'h55);
        expect_rd("keep_clo", O_CLO, 32'd100);
        expect_rd("keep_chi", O_CHI, 32'd0);
        expect_rd("keep_ctrl", O_CTRL, 32'd0);

        // ack in the same cycle as the pend rising edge: set wins
        wr(O_LO, 32'd0);
        wr(O_HI, 32'd0);
        wr(O_CLO, 32'd5);
        wr(O_CTRL, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            rd_en = 1'b1; addr = BASE;
            #1 v = rdata;
            rd_en = 1'b0; addr = 32'd0;
            if (v == 32'd5) found = 1'b1;
            else idle();
        end
        check("race_reach5", found, 1'b1);
        check("race_pend_before", timer_pend, 1'b0);
        intr_ack = 1'b1;
        @(posedge clk);
        #2 intr_ack = 1'b0;
        check("race_pend", timer_pend, 1'b1);
        check("race_irq", interrupt, 1'b1);
        idle();
        check("race_irq_hold", interrupt, 1'b1);

        // randomized traffic, checked every cycle by the compare process
        wr(O_CTRL, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, d, off;
            logic r, w, k;
            off = 32'($urandom_range(0, 7)) * 4;
            a = BASE + off;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) a = a + 32'h20;
            case (off)
                O_LO:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                        : m.mtime[31:0] + 32'($urandom_range(0, 8));
                O_HI:    d = 32'($urandom_range(0, 1));
                O_CLO:   d = m.mtime[31:0] + 32'($urandom_range(0, 40));
                O_CHI:   d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : m.mtime[63:32];
                O_CTRL:  d = {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 9) != 0)};
                default: d = $urandom;
            endcase
            w = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 2) == 0);
            k = ($urandom_range(0, 9) == 0);
            drive(r, w, a, d, k);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
